// File: rtl/ph_host_if.sv
// ph_host_if: host bus and FIFO read-side signals of the parasite-to-host port.
interface ph_host_if;
  logic       h_sel;
  logic       h_rdnw;
  logic [1:0] h_addr;
  logic [7:0] h_din;
  logic [7:0] h_dout;
  logic       h_irq_b;
  logic [7:0] fifo_data;
  logic       fifo_avail;
  logic       fifo_not_full;
  logic       fifo_rd;
  modport master (
    output h_sel, h_rdnw, h_addr, h_din, fifo_data, fifo_avail, fifo_not_full,
    input  h_dout, h_irq_b, fifo_rd
  );
  modport slave (
    input  h_sel, h_rdnw, h_addr, h_din, fifo_data, fifo_avail, fifo_not_full,
    output h_dout, h_irq_b, fifo_rd
  );
endinterface

// File: rtl/ph_host_port.sv
// ph_host_port: host read port that prefetches one FIFO byte and exposes status/data/control/count registers.
// Define PH_HOST_RDCOUNT_EN to add the 8-bit held-read counter at address 3.
module ph_host_port #(
  parameter int         FIFO_LAT       = 1,
  parameter logic [7:0] UNDERFLOW_BYTE = 8'hAA
) (
  input logic       h_phi2,
  input logic       h_rst_b,
  ph_host_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  state_t     state;
  logic [1:0] wait_cnt;
  logic [7:0] hold;
  logic [7:0] count;
  logic       valid;
  logic       ien;
  logic       udf;
  logic       rd_stat;
  logic       rd_data;
  logic       wr_ctrl;
  logic       flush;
  always_comb begin
    rd_stat = bus.h_sel & bus.h_rdnw & (bus.h_addr == 2'd0);
    rd_data = bus.h_sel & bus.h_rdnw & (bus.h_addr == 2'd1);
    wr_ctrl = bus.h_sel & ~bus.h_rdnw & (bus.h_addr == 2'd2);
    flush   = wr_ctrl & bus.h_din[7];
    bus.h_dout = (bus.h_addr == 2'd0) ? {valid, bus.fifo_not_full, udf, 5'b0} :
                 (bus.h_addr == 2'd1) ? (valid ? hold : UNDERFLOW_BYTE) :
                 (bus.h_addr == 2'd2) ? {7'b0, ien} : count;
  end
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state       <= IDLE;
      wait_cnt    <= 2'd0;
      hold        <= 8'h00;
      valid       <= 1'b0;
      ien         <= 1'b0;
      udf         <= 1'b0;
      bus.fifo_rd <= 1'b0;
      bus.h_irq_b <= 1'b1;
    end else begin
      bus.fifo_rd <= 1'b0;
      bus.h_irq_b <= ~(ien & valid);
      if (wr_ctrl) ien <= bus.h_din[0];
      if (rd_stat) udf <= 1'b0;
      if (rd_data && !valid) udf <= 1'b1;
      // A flush overrides every FSM action on its edge, including a completing fetch.
      if (flush) begin
        valid <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.fifo_avail) begin
            bus.fifo_rd <= 1'b1;
            wait_cnt    <= FIFO_LAT[1:0];
            state       <= FETCH;
          end
          FETCH: if (wait_cnt == 2'd0) begin
            hold  <= bus.fifo_data;
            valid <= 1'b1;
            state <= FULL;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
          FULL: if (rd_data) begin
            valid <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef PH_HOST_RDCOUNT_EN
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) count <= 8'h00;
    else if (bus.h_sel && !bus.h_rdnw && bus.h_addr == 2'd3) count <= 8'h00;
    else if (rd_data && valid) count <= count + 8'h01;
  end
`else
  assign count = 8'h00;
`endif
endmodule
